tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive-side counterpart to the mux-based TDM serializer.
- Takes one serial bit stream carrying CHANNELS time slots per frame, SLOT_BITS bits each, and steers each slot into a per-channel output register.
- Sits between the serial link and the per-channel consumers; flags each completed slot, each completed frame, and any framing errors.

Parameters:
CHANNELS  4  number of time slots per frame; >=2
SLOT_BITS  8  bits per slot; >=2
CW  2  channel counter width, clog2(CHANNELS)
BW  3  bit counter width, clog2(SLOT_BITS)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
din  input  1  serial data bit, MSB of each slot first
din_valid  input  1  din is sampled only in cycles where this is 1
frame_sync  input  1  high with din_valid marks bit 0 of slot 0 of a frame
ch_data  output  CHANNELS*SLOT_BITS  channel k occupies bits [k*SLOT_BITS +: SLOT_BITS]
ch_valid  output  CHANNELS  one-cycle pulse on bit k when slot k is written to ch_data
frame_done  output  1  one-cycle pulse when slot CHANNELS-1 completes
sync_err  output  1  one-cycle pulse on early frame_sync (frame restarted)
busy  output  1  1 while in RECEIVE

Behaviour:
- Reset is synchronous on clk; reset=1 at an edge forces state=HUNT and zeroes the shift register, bit counter, channel counter, ch_data, ch_valid, frame_done, sync_err and busy.
- Reset asserted mid-frame discards the partial slot and frame; no pulses are emitted.
- A sample is a rising edge with din_valid=1. Cycles with din_valid=0 stall: counters and shift register hold, and frame_sync is ignored.
- State HUNT (busy=0):
  - Samples without frame_sync are discarded.
  - A sample with frame_sync=1 takes din as bit 0 of slot 0. Set shift register={..,din}, bit_cnt=1, ch_cnt=0, and go to RECEIVE.
- State RECEIVE (busy=1), on each sample with frame_sync=0:
  - shift <= {shift[SLOT_BITS-2:0], din}; bit_cnt++.
  - When the sample is bit SLOT_BITS-1 of slot ch_cnt:
    - At the same edge, ch_data slice ch_cnt <= {shift[SLOT_BITS-2:0], din}.
    - ch_valid[ch_cnt] is asserted for exactly the next cycle (registered; latency 1 cycle after the last bit's edge).
    - bit_cnt resets to 0 and ch_cnt increments.
  - When that slot is CHANNELS-1:
    - frame_done pulses in the same cycle as ch_valid[CHANNELS-1].
    - ch_cnt wraps to 0 and state returns to HUNT.
- Sample with frame_sync=1 while in RECEIVE (early sync, any bit position):
  - sync_err pulses for one cycle.
  - The partial slot is discarded; already-completed slots of the aborted frame keep their ch_data values.
  - din becomes bit 0 of slot 0 of a new frame (bit_cnt=1, ch_cnt=0); remain in RECEIVE.
- frame_sync on the sample immediately after frame completion is legal (state is HUNT). This gives back-to-back frames with no gap and no sync_err.
- ch_data slices hold their value until overwritten by the next completion of the same slot. Slices of other channels are never disturbed.
- At most one ch_valid bit is high in any cycle. ch_valid, frame_done and sync_err are 0 whenever not pulsing.
- Counters never exceed SLOT_BITS-1 / CHANNELS-1. Widths of CW/BW must be sufficient; out-of-range values are unreachable.

Test Plan:
- Reset/idle: reset=1 for 2 cycles, then din toggling, frame_sync=0, din_valid=1 for 40 cycles -> all outputs 0, busy=0 throughout.
- Single frame, CHANNELS=4, SLOT_BITS=8: sync on first bit, stream 0xA5,0x3C,0xFF,0x01 MSB-first over 32 valid cycles.
  - ch_valid = 0001, 0010, 0100, 1000 one cycle after bits 8, 16, 24, 32.
  - frame_done coincides with 1000.
  - ch_data = 0x01FF3CA5, busy drops to 0.
- Stalls: same frame with din_valid=0 inserted every other cycle (64 cycles) -> identical ch_data 0x01FF3CA5, pulses delayed accordingly, no extra pulses.
- Back-to-back: frame 1 0x11,0x22,0x33,0x44, then frame_sync on the very next sample with frame 2 0x55,0x66,0x77,0x88 -> two frame_done pulses, no sync_err, final ch_data 0x88776655.
- Early sync: frame_sync reasserted on bit 3 of slot 1 after slot 0=0xA5.
  - sync_err one pulse; ch_data[7:0] stays 0xA5 until the new slot 0 completes.
  - The new frame completes correctly from that bit.
- Reset mid-frame: reset=1 during bit 5 of slot 2 -> ch_data=0, no ch_valid/frame_done, busy=0. The next frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bundles the serial link inputs and per-channel outputs of tdm_demux.
//   master : serial link side (drives din/din_valid/frame_sync, observes channel outputs)
//   slave  : demux side (observes serial inputs, drives ch_data/ch_valid/frame_done/sync_err/busy)
interface tdm_demux_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SLOT_BITS = 8
);
    logic                          din;
    logic                          din_valid;
    logic                          frame_sync;
    logic [CHANNELS*SLOT_BITS-1:0] ch_data;
    logic [CHANNELS-1:0]           ch_valid;
    logic                          frame_done;
    logic                          sync_err;
    logic                          busy;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_data, ch_valid, frame_done, sync_err, busy
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch_data, ch_valid, frame_done, sync_err, busy
    );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: splits a serial TDM stream (CHANNELS slots of SLOT_BITS bits, MSB first)
// into per-channel registers, pulsing a valid bit per completed slot plus frame/sync flags.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : tdm_demux_if.slave (din, din_valid, frame_sync in; ch_data, ch_valid,
//           frame_done, sync_err, busy out; all outputs registered)
module tdm_demux #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SLOT_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    tdm_demux_if.slave  bus
);
    localparam int unsigned CW = $clog2(CHANNELS);
    localparam int unsigned BW = $clog2(SLOT_BITS);

    typedef enum logic {HUNT, RECEIVE} state_t;

    state_t                        state;
    logic [SLOT_BITS-1:0]          shift;
    logic [BW-1:0]                 bit_cnt;
    logic [CW-1:0]                 ch_cnt;
    logic [CHANNELS*SLOT_BITS-1:0] ch_data;
    logic [CHANNELS-1:0]           ch_valid;
    logic                          frame_done;
    logic                          sync_err;
    logic                          busy;

    // Slot word as it will look once the current bit is shifted in.
    logic [SLOT_BITS-1:0]          word_c;
    assign word_c = {shift[SLOT_BITS-2:0], bus.din};

    // Frame state machine, shift register and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            shift      <= '0;
            bit_cnt    <= '0;
            ch_cnt     <= '0;
            ch_data    <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.frame_sync) begin
                            shift   <= SLOT_BITS'(bus.din);
                            bit_cnt <= BW'(1);
                            ch_cnt  <= '0;
                            state   <= RECEIVE;
                            busy    <= 1'b1;
                        end
                    end
                    RECEIVE: begin
                        if (bus.frame_sync) begin
                            // Early sync: drop the partial slot, restart at slot 0 bit 0.
                            sync_err <= 1'b1;
                            shift    <= SLOT_BITS'(bus.din);
                            bit_cnt  <= BW'(1);
                            ch_cnt   <= '0;
                        end else begin
                            shift <= word_c;
                            if (bit_cnt == BW'(SLOT_BITS - 1)) begin
                                bit_cnt <= '0;
                                for (int k = 0; k < int'(CHANNELS); k++) begin
                                    if (ch_cnt == CW'(k)) begin
                                        ch_data[k*SLOT_BITS +: SLOT_BITS] <= word_c;
                                        ch_valid[k] <= 1'b1;
                                    end
                                end
                                if (ch_cnt == CW'(CHANNELS - 1)) begin
                                    frame_done <= 1'b1;
                                    ch_cnt     <= '0;
                                    state      <= HUNT;
                                    busy       <= 1'b0;
                                end else begin
                                    ch_cnt <= ch_cnt + CW'(1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.ch_data    = ch_data;
    assign bus.ch_valid   = ch_valid;
    assign bus.frame_done = frame_done;
    assign bus.sync_err   = sync_err;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed stimulus for tdm_demux with a per-cycle expected-output
// scoreboard built from a bit-position model of the frame format.
module tb_tdm_demux;
    localparam int unsigned CH = 4;
    localparam int unsigned SB = 8;

    typedef struct packed {
        logic [CH*SB-1:0] data;
        logic [CH-1:0]    cv;
        logic             fd;
        logic             se;
        logic             bz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tdm_demux_if #(.CHANNELS(CH), .SLOT_BITS(SB)) bus ();

    tdm_demux #(.CHANNELS(CH), .SLOT_BITS(SB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: frame position counted as a flat bit index.
    logic             m_in_frame = 1'b0;
    int               m_pos      = 0;
    logic [SB-1:0]    m_cur      = '0;
    logic [CH*SB-1:0] m_data     = '0;

    int obs_fd = 0;
    int obs_se = 0;
    int obs_cv = 0;

    task automatic chk(input string tag, input logic [CH*SB-1:0] obs, input logic [CH*SB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic d, input logic v, input logic f);
        exp_t e;
        exp_t got;
        int   slot;
        @(negedge clk);
        reset          = r;
        bus.din        = d;
        bus.din_valid  = v;
        bus.frame_sync = f;
        e = '0;
        if (r) begin
            m_in_frame = 1'b0;
            m_pos      = 0;
            m_cur      = '0;
            m_data     = '0;
        end else if (v) begin
            if (f) begin
                e.se       = m_in_frame;
                m_in_frame = 1'b1;
                m_pos      = 1;
                m_cur      = SB'(d);
            end else if (m_in_frame) begin
                m_cur = {m_cur[SB-2:0], d};
                m_pos++;
                if (m_pos % SB == 0) begin
                    slot = m_pos / SB - 1;
                    m_data[slot*SB +: SB] = m_cur;
                    e.cv = CH'(1) << slot;
                    if (slot == CH - 1) begin
                        e.fd       = 1'b1;
                        m_in_frame = 1'b0;
                        m_pos      = 0;
                    end
                end
            end
        end
        e.data = m_data;
        e.bz   = m_in_frame;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("ch_data",    bus.ch_data,            got.data);
        chk("ch_valid",   (CH*SB)'(bus.ch_valid), (CH*SB)'(got.cv));
        chk("frame_done", (CH*SB)'(bus.frame_done), (CH*SB)'(got.fd));
        chk("sync_err",   (CH*SB)'(bus.sync_err), (CH*SB)'(got.se));
        chk("busy",       (CH*SB)'(bus.busy),     (CH*SB)'(got.bz));
        if (bus.frame_done) obs_fd++;
        if (bus.sync_err)   obs_se++;
        if (bus.ch_valid != '0) obs_cv++;
    endtask

    // One slot MSB-first; optional sync on its first bit; optional stall before each bit
    // (frame_sync is driven high during stalls and must be ignored).
    task automatic send_slot(input logic [SB-1:0] val, input logic sync, input logic stall);
        for (int i = SB - 1; i >= 0; i--) begin
            if (stall) cycle(1'b0, ~val[i], 1'b0, 1'b1);
            cycle(1'b0, val[i], 1'b1, sync && (i == SB - 1));
        end
    endtask

    task automatic send_frame(input logic [CH*SB-1:0] w, input logic stall);
        for (int s = 0; s < int'(CH); s++)
            send_slot(w[s*SB +: SB], s == 0, stall);
    endtask

    task automatic clr_obs();
        obs_fd = 0;
        obs_se = 0;
        obs_cv = 0;
    endtask

    initial begin
        logic [SB-1:0] b;
        reset          = 1'b1;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;

        // Reset then idle stream without sync
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        clr_obs();
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'(i), 1'b1, 1'b0);
        chk("idle_pulses", 32'(obs_cv + obs_fd + obs_se), 32'd0);
        chk("idle_data", bus.ch_data, 32'h0);

        // Single frame
        clr_obs();
        send_frame(32'h01FF3CA5, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame_data", bus.ch_data, 32'h01FF3CA5);
        chk("frame_busy", 32'(bus.busy), 32'd0);
        chk("frame_cv_cnt", 32'(obs_cv), 32'd4);
        chk("frame_fd_cnt", 32'(obs_fd), 32'd1);

        // Same frame with stalls after a reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_data", bus.ch_data, 32'h0);
        clr_obs();
        send_frame(32'h01FF3CA5, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_data", bus.ch_data, 32'h01FF3CA5);
        chk("stall_cv_cnt", 32'(obs_cv), 32'd4);
        chk("stall_se_cnt", 32'(obs_se), 32'd0);

        // Back-to-back frames
        clr_obs();
        send_frame(32'h44332211, 1'b0);
        chk("b2b_mid_data", bus.ch_data, 32'h44332211);
        send_frame(32'h88776655, 1'b0);
        chk("b2b_data", bus.ch_data, 32'h88776655);
        chk("b2b_fd_cnt", 32'(obs_fd), 32'd2);
        chk("b2b_se_cnt", 32'(obs_se), 32'd0);

        // Early sync on bit 3 of slot 1
        clr_obs();
        send_slot(8'hA5, 1'b1, 1'b0);
        b = 8'h3C;
        for (int i = SB - 1; i > SB - 4; i--) cycle(1'b0, b[i], 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("early_se_cnt", 32'(obs_se), 32'd1);
        chk("early_busy", 32'(bus.busy), 32'd1);
        b = 8'h12;
        for (int i = SB - 2; i >= 0; i--) begin
            if (i == 1) chk("early_keep_slot0", 32'(bus.ch_data[7:0]), 32'hA5);
            cycle(1'b0, b[i], 1'b1, 1'b0);
        end
        send_slot(8'h34, 1'b0, 1'b0);
        send_slot(8'h56, 1'b0, 1'b0);
        send_slot(8'h78, 1'b0, 1'b0);
        chk("early_data", bus.ch_data, 32'h78563412);
        chk("early_se_final", 32'(obs_se), 32'd1);

        // Reset during bit 5 of slot 2
        clr_obs();
        send_slot(8'h9A, 1'b1, 1'b0);
        send_slot(8'hBC, 1'b0, 1'b0);
        b = 8'hF0;
        for (int i = SB - 1; i > SB - 6; i--) cycle(1'b0, b[i], 1'b1, 1'b0);
        clr_obs();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("midrst_data", bus.ch_data, 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("midrst_pulses", 32'(obs_cv + obs_fd + obs_se), 32'd0);
        send_frame(32'hEFBEADDE, 1'b0);
        chk("post_rst_data", bus.ch_data, 32'hEFBEADDE);
        chk("post_rst_fd_cnt", 32'(obs_fd), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
